bram_burst_reader: RTL and testbench

//  Read-side initiator for one port of an RAMB16 block RAM (9-bit addr, 32-bit data, 1-cycle registered read).

---
 rtl/bram_burst_reader.sv | 182 ++++++++++++++++++
 tb/tb_bram_burst_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_reader.sv
// bram_burst_reader: read-side burst initiator for one RAMB16 port.
// Accepts {base, length} commands, issues sequential single-cycle reads and
// returns the words as a ready/valid stream tagged with a last flag. A 2-entry
// buffer absorbs the one-cycle RAM read latency under backpressure.

// Occupancy checker: words buffered plus the read in flight never exceed 2.
module bram_burst_reader_chk (
  input logic       CLK,
  input logic       reset,
  input logic [1:0] count,
  input logic       pending
);

  // A third outstanding word would have nowhere to land in the buffer.
  occupancy_bound: assert property (@(posedge CLK) disable iff (reset)
    (({1'b0, count} + {2'b00, pending}) <= 3'd2));

endmodule

module bram_burst_reader #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 10
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_ssr,
  output logic [ADDR_BITS-1:0] ram_addr,
  input  logic [DATA_BITS-1:0] ram_dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [ADDR_BITS-1:0] base;
  logic [LEN_BITS-1:0]  len;
  logic [LEN_BITS-1:0]  issued;
  logic                 pending;
  logic                 pend_last;

  // Two-entry word buffer; rd_ptr selects the head, wr_ptr the tail.
  logic [DATA_BITS-1:0] buf_data [2];
  logic                 buf_last [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;

  logic                 pop;
  logic                 issue;
  logic                 issue_last;
  logic [2:0]           occ_after_pop;
  logic                 cmd_take;

  // Write side of the port is never used.
  assign ram_we  = 1'b0;
  assign ram_ssr = 1'b0;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == READ) || (state == DRAIN);
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_last  = buf_last[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign cmd_take  = cmd_valid & cmd_ready;

  // Issue decision: a read may start only if its word is guaranteed a slot,
  // counting the word in flight and crediting a pop happening this cycle.
  always_comb begin
    occ_after_pop = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    issue_last    = (issued == (len - LEN_BITS'(1)));
    if ((state == READ) && (issued < len) && (occ_after_pop < 3'd2)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
    ram_en   = issue;
    ram_addr = base + issued[ADDR_BITS-1:0];
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_take && (cmd_len != {LEN_BITS{1'b0}})) begin
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (issue && issue_last) begin
          state_next = DRAIN;
        end else begin
          state_next = READ;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, latched command and read-issue bookkeeping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= {ADDR_BITS{1'b0}};
      len       <= {LEN_BITS{1'b0}};
      issued    <= {LEN_BITS{1'b0}};
      pending   <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= issue;
      pend_last <= issue & issue_last;
      if (cmd_take && (cmd_len != {LEN_BITS{1'b0}})) begin
        base   <= cmd_addr;
        len    <= cmd_len;
        issued <= {LEN_BITS{1'b0}};
      end else if (issue) begin
        issued <= issued + LEN_BITS'(1);
      end else begin
        issued <= issued;
      end
    end
  end

  // Buffer: the word read last cycle lands at the tail; the head leaves on pop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= {DATA_BITS{1'b0}};
        buf_last[i] <= 1'b0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pending) begin
        buf_data[wr_ptr] <= ram_dout;
        buf_last[wr_ptr] <= pend_last;
        wr_ptr           <= ~wr_ptr;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end else begin
        rd_ptr <= rd_ptr;
      end
      count <= count + {1'b0, pending} - {1'b0, pop};
    end
  end

  bram_burst_reader_chk u_chk (
    .CLK     (CLK),
    .reset   (reset),
    .count   (count),
    .pending (pending)
  );

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: a RAM model answers reads with
// RAM[i] = i*0x01010101; bursts come from a vector table plus hand sequences
// for zero-length commands and reset in mid-burst.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic        ram_en;
  logic        ram_we;
  logic        ram_ssr;
  logic [8:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [8:0]  addr;
    logic [9:0]  len;
    logic [15:0] pat;         // out_ready per cycle, bit 0 first, repeating
    logic [31:0] first_word;
    logic [31:0] final_word;
    int          exp_cycles;  // accept-to-last-pop cycles, 0 = not checked
  } vec_t;

  vec_t vecs [5];

  bram_burst_reader dut (
    .CLK       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_ssr   (ram_ssr),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [8:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // RAM model: registered read, data valid the cycle after EN.
  always @(posedge clk) begin
    if (ram_en) ram_dout <= ram_word(ram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int cyc, got, iss, occ, first_cyc, done_cyc;
    logic pop, exp_en;
    logic [31:0] first_w, final_w;
    first_w = 32'd0;
    final_w = 32'd0;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = 10'd0;
    got = 0; iss = 0; occ = 0; cyc = 1; first_cyc = 0; done_cyc = 0;
    while ((got < int'(v.len)) && (cyc <= int'(v.len) + 64)) begin
      out_ready = v.pat[(cyc - 1) % 16];
      #1;
      if (out_valid && (first_cyc == 0)) first_cyc = cyc;
      pop    = out_valid & out_ready;
      exp_en = (iss < int'(v.len)) && ((occ - (pop ? 1 : 0)) < 2);
      check("ram_en", 32'(ram_en), 32'(exp_en));
      check("busy", 32'(busy), 32'd1);
      check("ram_we_ssr", {30'd0, ram_we, ram_ssr}, 32'd0);
      if (ram_en) begin
        check("ram_addr", 32'(ram_addr), 32'((int'(v.addr) + iss) % 512));
        iss++;
        occ++;
      end
      if (pop) begin
        check("out_data", out_data, ram_word(9'(int'(v.addr) + got)));
        check("out_last", 32'(out_last), 32'(got == int'(v.len) - 1));
        if (got == 0) first_w = out_data;
        final_w = out_data;
        got++;
        occ--;
        if (got == int'(v.len)) done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    check("words_received", 32'(got), 32'(v.len));
    check("first_word", first_w, v.first_word);
    check("final_word", final_w, v.final_word);
    if (v.exp_cycles != 0) begin
      check("done_cycle", 32'(done_cyc), 32'(v.exp_cycles));
      check("first_valid_cycle", 32'(first_cyc), 32'd3);
    end
    #1;
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pops;
    vecs[0] = '{9'h010, 10'd4,   16'hFFFF, 32'h10101010, 32'h13131313, 6};
    vecs[1] = '{9'h020, 10'd8,   16'h6969, 32'h20202020, 32'h27272727, 0};
    vecs[2] = '{9'h1FE, 10'd4,   16'hFFFF, 32'hFFFFFFFE, 32'h01010101, 6};
    vecs[3] = '{9'h000, 10'd512, 16'hFFFF, 32'h00000000, 32'h010100FF, 514};
    vecs[4] = '{9'h0AA, 10'd3,   16'hFF00, 32'hAAAAAAAA, 32'hACACACAC, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 9'd0; cmd_len = 10'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Zero-length command: accepted, but nothing happens.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 9'h033; cmd_len = 10'd0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("len0_ram_en", 32'(ram_en), 32'd0);
      check("len0_out_valid", 32'(out_valid), 32'd0);
      check("len0_cmd_ready", 32'(cmd_ready), 32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    run_burst('{9'h005, 10'd1, 16'hFFFF, 32'h05050505, 32'h05050505, 3});

    // Reset in mid-burst after three pops.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 9'h040; cmd_len = 10'd16; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    pops = 0;
    for (int i = 0; i < 40 && pops < 3; i++) begin
      #1;
      if (out_valid) pops++;
      @(negedge clk);
    end
    check("pops_before_reset", 32'(pops), 32'd3);
    #1;
    check("busy_before_reset", 32'(busy), 32'd1);
    check("valid_before_reset", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    run_burst('{9'h100, 10'd2, 16'hFFFF, 32'h01010100, 32'h02020201, 4});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
